// File: rtl/multicycle_controller_pkg.sv
// Purpose: shared constants for the multi-cycle MIPS controller: opcodes, funct codes, ALU codes, state encoding, PCSrc codes.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package multicycle_controller_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    // ALU32Bit control codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    // State encoding (visible on the debug State port)
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_BRANCH = 3'd5;
    localparam logic [2:0] S_JUMP   = 3'd6;

    typedef enum logic [2:0] {
        ST_FETCH  = S_FETCH,
        ST_DECODE = S_DECODE,
        ST_EXEC   = S_EXEC,
        ST_MEM    = S_MEM,
        ST_WB     = S_WB,
        ST_BRANCH = S_BRANCH,
        ST_JUMP   = S_JUMP
    } state_t;

    // PCSrc select codes
    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for opcodes that enter EXEC (R-type funct is checked separately)
    function automatic logic op_uses_exec(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decode.sv
// Purpose: combinational ALU control decode from (Opcode, Funct, State) to ALUOp, RegB and a funct-valid flag.
// Latency: combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
// Ports: i_opcode/i_funct held IR fields, i_state controller state; o_alu_op ALU code,
//        o_reg_b shamt select, o_funct_valid R-type funct is defined (independent of state).
module alu_decode
    import multicycle_controller_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic [2:0] i_state,
    output logic [3:0] o_alu_op,
    output logic       o_reg_b,
    output logic       o_funct_valid
);

    logic [3:0] w_funct_alu;
    logic       w_funct_shift;

    always_comb begin
        w_funct_alu   = ALU_ADD;
        w_funct_shift = 1'b0;
        o_funct_valid = 1'b1;
        case (i_funct)
            FN_ADD:  w_funct_alu = ALU_ADD;
            FN_SUB:  w_funct_alu = ALU_SUB;
            FN_AND:  w_funct_alu = ALU_AND;
            FN_OR:   w_funct_alu = ALU_OR;
            FN_SLT:  w_funct_alu = ALU_SLT;
            FN_SLL: begin
                w_funct_alu   = ALU_SLL;
                w_funct_shift = 1'b1;
            end
            FN_SRL: begin
                w_funct_alu   = ALU_SRL;
                w_funct_shift = 1'b1;
            end
            default: o_funct_valid = 1'b0;
        endcase
    end

    // ALU control is only meaningful in EXEC and BRANCH; elsewhere it rests at 0.
    always_comb begin
        o_alu_op = 4'b0000;
        o_reg_b  = 1'b0;
        if (i_state == S_EXEC) begin
            if (i_opcode == OP_RTYPE) begin
                o_alu_op = w_funct_alu;
                o_reg_b  = w_funct_shift;
            end else begin
                // addi / lw / sw all add the immediate
                o_alu_op = ALU_ADD;
            end
        end else if (i_state == S_BRANCH) begin
            o_alu_op = ALU_SUB;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: Moore sequencer for the multi-cycle MIPS datapath: state register, next-state, enable/select decode, Illegal flag, retire counter.
// Latency: R/addi 4, lw 5+N, sw 4+N, beq/bne 3, j 3, illegal 2 cycles (N = MemReady-low cycles in MEM).
// Backpressure: holds in MEM while i_mem_ready=0; i_mem_ready ignored in other states.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_opcode/i_funct held IR fields; i_zero ALU zero flag;
//        i_mem_ready data memory done; o_* datapath enables/selects; o_illegal sticky decode error;
//        o_state debug state; o_retired completed-instruction count (wraps).
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [5:0]       i_opcode,
    input  logic [5:0]       i_funct,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic             o_pc_write,
    output logic [1:0]       o_pc_src,
    output logic             o_ir_write,
    output logic             o_reg_write,
    output logic             o_reg_dst,
    output logic             o_mem_to_reg,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_alu_src,
    output logic             o_reg_b,
    output logic [3:0]       o_alu_op,
    output logic             o_illegal,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_retired
);

    state_t            r_state;
    state_t            w_next;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_retired;

    logic       w_retire;
    logic       w_illegal_dec;
    logic       w_pc_write;
    logic [1:0] w_pc_src;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_alu_src;
    logic [3:0] w_alu_op;
    logic       w_reg_b;
    logic       w_funct_valid;

    alu_decode u_alu_decode (
        .i_opcode      (i_opcode),
        .i_funct       (i_funct),
        .i_state       (r_state),
        .o_alu_op      (w_alu_op),
        .o_reg_b       (w_reg_b),
        .o_funct_valid (w_funct_valid)
    );

    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        w_illegal_dec = 1'b0;
        w_pc_write    = 1'b0;
        w_pc_src      = PCSRC_SEQ;
        w_ir_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_reg_dst     = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_alu_src     = 1'b0;
        unique case (r_state)
            ST_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                w_pc_src   = PCSRC_SEQ;
                w_next     = ST_DECODE;
            end
            ST_DECODE: begin
                if (i_opcode == OP_RTYPE && !w_funct_valid) begin
                    w_illegal_dec = 1'b1;
                    w_next        = ST_FETCH;
                end else if (op_uses_exec(i_opcode)) begin
                    w_next = ST_EXEC;
                end else if (i_opcode == OP_BEQ || i_opcode == OP_BNE) begin
                    w_next = ST_BRANCH;
                end else if (i_opcode == OP_J) begin
                    w_next = ST_JUMP;
                end else begin
                    w_illegal_dec = 1'b1;
                    w_next        = ST_FETCH;
                end
            end
            ST_EXEC: begin
                w_alu_src = (i_opcode != OP_RTYPE);
                w_next    = (i_opcode == OP_LW || i_opcode == OP_SW) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                w_mem_read  = (i_opcode == OP_LW);
                w_mem_write = (i_opcode == OP_SW);
                if (i_mem_ready) begin
                    if (i_opcode == OP_LW) begin
                        w_next = ST_WB;
                    end else begin
                        w_next   = ST_FETCH;
                        w_retire = 1'b1;
                    end
                end
            end
            ST_WB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = (i_opcode == OP_RTYPE);
                w_mem_to_reg = (i_opcode == OP_LW);
                w_retire     = 1'b1;
                w_next       = ST_FETCH;
            end
            ST_BRANCH: begin
                w_pc_src   = PCSRC_BRANCH;
                // Only this enable looks at a same-cycle datapath flag.
                w_pc_write = (i_opcode == OP_BNE) ? ~i_zero : i_zero;
                w_retire   = 1'b1;
                w_next     = ST_FETCH;
            end
            ST_JUMP: begin
                w_pc_src   = PCSRC_JUMP;
                w_pc_write = 1'b1;
                w_retire   = 1'b1;
                w_next     = ST_FETCH;
            end
            default: w_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_FETCH;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_illegal_dec) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // Held reset forces every enable and select low even though the state is
    // already FETCH, so an interrupted access cannot complete.
    assign o_pc_write   = w_pc_write   & i_rst_n;
    assign o_pc_src     = i_rst_n ? w_pc_src : 2'b00;
    assign o_ir_write   = w_ir_write   & i_rst_n;
    assign o_reg_write  = w_reg_write  & i_rst_n;
    assign o_reg_dst    = w_reg_dst    & i_rst_n;
    assign o_mem_to_reg = w_mem_to_reg & i_rst_n;
    assign o_mem_read   = w_mem_read   & i_rst_n;
    assign o_mem_write  = w_mem_write  & i_rst_n;
    assign o_alu_src    = w_alu_src    & i_rst_n;
    assign o_reg_b      = w_reg_b      & i_rst_n;
    assign o_alu_op     = i_rst_n ? w_alu_op : 4'b0000;
    assign o_illegal    = r_illegal;
    assign o_state      = r_state;
    assign o_retired    = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic        d_pcw, d_irw, d_rw, d_rdst, d_m2r, d_mr, d_mw, d_alusrc, d_regb, d_ill;
    logic [1:0]  d_pcsrc;
    logic [3:0]  d_aluop;
    logic [2:0]  d_state;
    logic [31:0] d_ret;

    logic        s_pcw, s_irw, s_rw, s_rdst, s_m2r, s_mr, s_mw, s_alusrc, s_regb, s_ill;
    logic [1:0]  s_pcsrc;
    logic [3:0]  s_aluop;
    logic [2:0]  s_state;
    logic [2:0]  s_ret;

    multicycle_controller #(.CNT_W(32)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_funct(funct),
        .i_zero(zero), .i_mem_ready(mem_ready),
        .o_pc_write(d_pcw), .o_pc_src(d_pcsrc), .o_ir_write(d_irw), .o_reg_write(d_rw),
        .o_reg_dst(d_rdst), .o_mem_to_reg(d_m2r), .o_mem_read(d_mr), .o_mem_write(d_mw),
        .o_alu_src(d_alusrc), .o_reg_b(d_regb), .o_alu_op(d_aluop), .o_illegal(d_ill),
        .o_state(d_state), .o_retired(d_ret)
    );

    // Narrow counter copy: same stimulus, wraps every 8 retires.
    multicycle_controller #(.CNT_W(3)) u_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_funct(funct),
        .i_zero(zero), .i_mem_ready(mem_ready),
        .o_pc_write(s_pcw), .o_pc_src(s_pcsrc), .o_ir_write(s_irw), .o_reg_write(s_rw),
        .o_reg_dst(s_rdst), .o_mem_to_reg(s_m2r), .o_mem_read(s_mr), .o_mem_write(s_mw),
        .o_alu_src(s_alusrc), .o_reg_b(s_regb), .o_alu_op(s_aluop), .o_illegal(s_ill),
        .o_state(s_state), .o_retired(s_ret)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic        pcw;
        logic [1:0]  pcsrc;
        logic        irw;
        logic        rw;
        logic        rdst;
        logic        m2r;
        logic        mr;
        logic        mw;
        logic        alusrc;
        logic        regb;
        logic [3:0]  aluop;
        logic        ill;
        logic [31:0] ret;
    } obs_t;

    obs_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ret;
    logic        exp_ill;

    // Monitor: one expected observation per cycle, compared mid-cycle.
    always @(negedge clk) begin : monitor
        obs_t e;
        obs_t a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {d_state, d_pcw, d_pcsrc, d_irw, d_rw, d_rdst, d_m2r, d_mr, d_mw,
                 d_alusrc, d_regb, d_aluop, d_ill, d_ret};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t actual st=%0d ctl=%h ill=%b ret=%0d required st=%0d ctl=%h ill=%b ret=%0d",
                         $time, a.st, a[47:33], a.ill, a.ret, e.st, e[47:33], e.ill, e.ret);
            end
            checks++;
            if (s_ret !== e.ret[2:0]) begin
                errors++;
                $display("FAIL retired_wrap3 t=%0t actual=%0d required=%0d", $time, s_ret, e.ret[2:0]);
            end
        end
    end

    task automatic cyc(input logic [2:0] st, input logic pcw, input logic [1:0] pcsrc,
                       input logic irw, input logic rw, input logic rdst, input logic m2r,
                       input logic mr, input logic mw, input logic alusrc, input logic regb,
                       input logic [3:0] aluop, input logic retire, input logic set_ill);
        obs_t e;
        e = {st, pcw, pcsrc, irw, rw, rdst, m2r, mr, mw, alusrc, regb, aluop, exp_ill, exp_ret};
        q.push_back(e);
        @(posedge clk);
        #1;
        if (retire)  exp_ret = exp_ret + 32'd1;
        if (set_ill) exp_ill = 1'b1;
    endtask

    task automatic idle_cyc();
        cyc(S_FETCH, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    endtask

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
        cyc(S_FETCH, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    endtask

    task automatic decode(input logic si);
        cyc(S_DECODE, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, si);
    endtask

    task automatic do_r(input logic [5:0] fn, input logic [3:0] aluop, input logic regb);
        fetch(OP_RTYPE, fn);
        decode(0);
        cyc(S_EXEC, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, regb, aluop, 0, 0);
        cyc(S_WB,   0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 1, 0);
    endtask

    task automatic do_addi();
        fetch(OP_ADDI, 6'b010101);
        decode(0);
        cyc(S_EXEC, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0);
        cyc(S_WB,   0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0);
    endtask

    task automatic do_lw(input int waits);
        fetch(OP_LW, 6'b000000);
        decode(0);
        cyc(S_EXEC, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0);
        mem_ready = 1'b0;
        for (int i = 0; i < waits; i++)
            cyc(S_MEM, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0);
        mem_ready = 1'b1;
        cyc(S_MEM, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0);
        mem_ready = 1'b0;
        cyc(S_WB,  0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 4'b0000, 1, 0);
    endtask

    task automatic do_sw(input int waits);
        fetch(OP_SW, 6'b100000);
        decode(0);
        cyc(S_EXEC, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0);
        mem_ready = 1'b0;
        for (int i = 0; i < waits; i++)
            cyc(S_MEM, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 0, 0);
        mem_ready = 1'b1;
        cyc(S_MEM, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 1, 0);
        mem_ready = 1'b0;
    endtask

    task automatic do_branch(input logic [5:0] op, input logic z, input logic exp_pcw);
        fetch(op, 6'b000000);
        decode(0);
        zero = z;
        cyc(S_BRANCH, exp_pcw, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 1, 0);
        zero = 1'b0;
    endtask

    task automatic do_j();
        fetch(OP_J, 6'b000000);
        decode(0);
        cyc(S_JUMP, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0);
    endtask

    task automatic do_illegal(input logic [5:0] op, input logic [5:0] fn);
        fetch(op, fn);
        decode(1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog t=%0t bench did not complete", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n     = 1'b0;
        opcode    = 6'b000000;
        funct     = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        exp_ret   = 32'd0;
        exp_ill   = 1'b0;
        @(posedge clk);
        #1;
        // Reset state: FETCH, everything gated off
        idle_cyc();
        idle_cyc();
        rst_n = 1'b1;

        // add from reset, with MemReady high outside MEM (must be ignored)
        mem_ready = 1'b1;
        do_r(FN_ADD, 4'b0000, 0);
        mem_ready = 1'b0;

        // lw with 3 wait cycles: 8 cycles total
        do_lw(3);

        // Branches, both polarities of Zero
        do_branch(OP_BEQ, 1'b1, 1'b1);
        do_branch(OP_BEQ, 1'b0, 1'b0);
        do_branch(OP_BNE, 1'b0, 1'b1);
        do_branch(OP_BNE, 1'b1, 1'b0);

        // Remaining R-type funct map and immediate forms
        do_r(FN_SUB, 4'b0001, 0);
        do_r(FN_AND, 4'b0010, 0);
        do_r(FN_OR,  4'b0011, 0);
        do_r(FN_SLT, 4'b0100, 0);
        do_r(FN_SLL, 4'b1000, 1);
        do_r(FN_SRL, 4'b1001, 1);
        do_addi();
        do_sw(0);
        do_sw(2);
        do_j();

        // Illegal opcode, then illegal funct; flag sticks across a valid add
        do_illegal(6'b111111, 6'b100000);
        do_illegal(OP_RTYPE, 6'b111111);
        do_r(FN_ADD, 4'b0000, 0);

        // Reset in the middle of a stalled sw
        fetch(OP_SW, 6'b000000);
        decode(0);
        cyc(S_EXEC, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0);
        mem_ready = 1'b0;
        cyc(S_MEM,  0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 0, 0);
        rst_n   = 1'b0;
        exp_ret = 32'd0;
        exp_ill = 1'b0;
        idle_cyc();
        idle_cyc();
        rst_n = 1'b1;

        // First post-release cycle is a FETCH with IRWrite
        do_j();
        do_j();
        do_lw(0);

        idle_drain();
    end

    task automatic idle_drain();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

endmodule
